// File: rtl/pool_pkg.sv
// Shared constants and state encoding for the layer-2 2x2/stride-2 max-pooling sequencer.
package pool_pkg;

  localparam int FEATURE_BITWIDTH = 8;
  localparam int CHANNELS         = 8;
  localparam int L2_IN_W          = 12;
  localparam int L2_IN_H          = 12;
  localparam int L2_OUT_W         = L2_IN_W / 2;
  localparam int L2_OUT_H         = L2_IN_H / 2;
  localparam int L2_WORD_W        = CHANNELS * FEATURE_BITWIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } pool_state_e;

endpackage

// File: rtl/pool_max_accum.sv
// Per-channel unsigned running maximum; load overwrites, otherwise keeps the larger value (ties keep acc).
module pool_max_accum
  import pool_pkg::*;
#(
  parameter int CHANNELS         = pool_pkg::CHANNELS,
  parameter int FEATURE_BITWIDTH = pool_pkg::FEATURE_BITWIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr,
  input  logic                                 en,
  input  logic                                 load,
  input  logic [CHANNELS*FEATURE_BITWIDTH-1:0] din,
  output logic [CHANNELS*FEATURE_BITWIDTH-1:0] acc
);

  localparam int FB = FEATURE_BITWIDTH;

  logic [CHANNELS*FB-1:0] acc_nxt;

  function automatic logic [FB-1:0] max_u(input logic [FB-1:0] cur, input logic [FB-1:0] val);
    return (val > cur) ? val : cur;
  endfunction

  always_comb begin
    acc_nxt = acc;
    for (int c = 0; c < CHANNELS; c++) begin
      if (load) acc_nxt[c*FB +: FB] = din[c*FB +: FB];
      else      acc_nxt[c*FB +: FB] = max_u(acc[c*FB +: FB], din[c*FB +: FB]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end

endmodule

// File: rtl/pool2_window_scheduler.sv
// Streams 2x2/stride-2 max pooling over a buffered feature map: 4 reads per window, one pooled write.
module pool2_window_scheduler #(
  parameter int CHANNELS         = pool_pkg::CHANNELS,
  parameter int FEATURE_BITWIDTH = pool_pkg::FEATURE_BITWIDTH,
  parameter int IN_W             = pool_pkg::L2_IN_W,
  parameter int IN_H             = pool_pkg::L2_IN_H,
  parameter int IN_ADDR_W        = 8,
  parameter int OUT_ADDR_W       = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 soft_rst,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_en,
  output logic [IN_ADDR_W-1:0]                 rd_addr,
  input  logic [CHANNELS*FEATURE_BITWIDTH-1:0] rd_data,
  output logic                                 wr_valid,
  input  logic                                 wr_ready,
  output logic [OUT_ADDR_W-1:0]                wr_addr,
  output logic [CHANNELS*FEATURE_BITWIDTH-1:0] wr_data
);
  import pool_pkg::*;

  localparam int OUT_W  = IN_W / 2;
  localparam int OUT_H  = IN_H / 2;
  localparam int WORD_W = CHANNELS * FEATURE_BITWIDTH;
  localparam int XW     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW     = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  pool_state_e     state, state_nxt;
  logic [1:0]      k;
  logic [XW-1:0]   ox;
  logic [YW-1:0]   oy;
  logic            last_win, wr_fire;
  logic            rd_vld_p1, rd_load_p1;
  logic [IN_ADDR_W-1:0] row, col;
  logic [WORD_W-1:0]    acc;

  assign last_win = (ox == XW'(OUT_W - 1)) && (oy == YW'(OUT_H - 1));
  assign wr_fire  = (state == ST_WRITE) && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= ST_IDLE;
    else if (soft_rst) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (k == 2'd3) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_WRITE;
      ST_WRITE: if (wr_ready) state_nxt = last_win ? ST_DONE : ST_READ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Window walk: k steps the 2x2 taps, ox/oy advance on each accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k  <= '0;
      ox <= '0;
      oy <= '0;
    end else if (soft_rst) begin
      k  <= '0;
      ox <= '0;
      oy <= '0;
    end else if (state == ST_READ) begin
      k <= k + 2'd1;
    end else if (wr_fire) begin
      if (last_win) begin
        ox <= '0;
        oy <= '0;
      end else if (ox == XW'(OUT_W - 1)) begin
        ox <= '0;
        oy <= oy + YW'(1);
      end else begin
        ox <= ox + XW'(1);
      end
    end
  end

  // p1: read data returns one cycle after rd_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1  <= 1'b0;
      rd_load_p1 <= 1'b0;
    end else if (soft_rst) begin
      rd_vld_p1  <= 1'b0;
      rd_load_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= rd_en;
      rd_load_p1 <= rd_en && (k == 2'd0);
    end
  end

  pool_max_accum #(
    .CHANNELS        (CHANNELS),
    .FEATURE_BITWIDTH(FEATURE_BITWIDTH)
  ) u_accum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (soft_rst),
    .en   (rd_vld_p1),
    .load (rd_load_p1),
    .din  (rd_data),
    .acc  (acc)
  );

  assign row      = IN_ADDR_W'({oy, k[1]});
  assign col      = IN_ADDR_W'({ox, k[0]});
  assign rd_en    = (state == ST_READ);
  assign rd_addr  = rd_en ? (row * IN_ADDR_W'(IN_W) + col) : '0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign wr_valid = (state == ST_WRITE);
  assign wr_addr  = OUT_ADDR_W'(oy) * OUT_ADDR_W'(OUT_W) + OUT_ADDR_W'(ox);
  assign wr_data  = acc;

endmodule

// File: tb/tb_pool2_window_scheduler.sv
// Randomized bench for pool2_window_scheduler against a window-max reference model of the frame.
module tb_pool2_window_scheduler;

  localparam int IW = 12, IH = 12, OW = 6, OH = 6, NWIN = 36;

  logic        clk = 1'b0;
  logic        rst_n, soft_rst, start, wr_ready;
  logic        busy, done, rd_en, wr_valid;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data = '0;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] mem   [IW*IH];
  logic [63:0] exp_w [NWIN];
  logic [63:0] got_w [NWIN];

  pool2_window_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .soft_rst(soft_rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
  endtask

  // Reference: each pooled channel is the max of its four window pixels.
  function automatic void build_expected();
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int c = 0; c < 8; c++) begin
          logic [7:0] m, v;
          m = 8'd0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = mem[(2*oy+dy)*IW + 2*ox+dx][c*8 +: 8];
              if (v > m) m = v;
            end
          exp_w[oy*OW+ox][c*8 +: 8] = m;
        end
  endfunction

  function automatic void fill_ramp();
    for (int p = 0; p < IW*IH; p++)
      for (int c = 0; c < 8; c++) mem[p][c*8 +: 8] = 8'((p + c) % 256);
  endfunction

  function automatic void fill_random();
    for (int p = 0; p < IW*IH; p++) mem[p] = {$urandom, $urandom};
  endfunction

  function automatic void fill_position();
    for (int p = 0; p < IW*IH; p++) mem[p] = {8{8'd5}};
    for (int wi = 0; wi < NWIN; wi++) begin
      int oy, ox;
      oy = wi / OW;
      ox = wi % OW;
      for (int q = 0; q < 4; q++) begin
        int pix;
        pix = (2*oy + q/2)*IW + 2*ox + q%2;
        if (wi % 3 == 0) mem[pix] = {8{8'd7}};
        else
          for (int c = 0; c < 8; c++)
            if ((c + wi) % 4 == q) mem[pix][c*8 +: 8] = 8'd200;
      end
    end
  endfunction

  // mode 0: ready high, 1: hold off write 10 for 5 cycles, 2: random ready
  task automatic run_frame(input int mode, input bit poke_start, input string nm);
    int w, n_done, done_cyc, stalls, stall_used, busy_err, post_err, proto_err;
    logic [63:0] hold_d;
    w = 0; n_done = 0; done_cyc = 0; stalls = 0; stall_used = 0;
    busy_err = 0; post_err = 0; proto_err = 0; hold_d = '0;
    build_expected();
    start = 1'b1;
    wr_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 1500; cyc++) begin
      #1;
      start = 1'b0;
      if (poke_start && cyc == 50) start = 1'b1;
      if (done) begin
        n_done++;
        if (n_done == 1) done_cyc = cyc;
        if (poke_start) start = 1'b1;
      end
      if (n_done == 0 || cyc == done_cyc) begin
        if (!busy) busy_err++;
      end else if (busy || rd_en || wr_valid) post_err++;
      if (rd_en && wr_valid) proto_err++;
      wr_ready = 1'b1;
      if (mode == 1 && w == 10 && stall_used > 0 && stall_used < 5) begin
        check({nm, "_stall_valid"}, 64'(wr_valid), 64'd1);
        check({nm, "_stall_addr"}, 64'(wr_addr), 64'd10);
        check({nm, "_stall_data"}, wr_data, hold_d);
        wr_ready = 1'b0;
        stall_used++;
      end else if (wr_valid) begin
        if (mode == 1 && w == 10 && stall_used == 0) begin
          hold_d = wr_data;
          wr_ready = 1'b0;
          stall_used = 1;
        end else if (mode == 2) wr_ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) wr_ready = 1'($urandom_range(0, 1));
      if (wr_valid && !wr_ready) stalls++;
      if (wr_valid && wr_ready) begin
        if (w < NWIN) begin
          got_w[w] = wr_data;
          check({nm, "_wr_addr"}, 64'(wr_addr), 64'(w));
          check({nm, "_wr_data"}, wr_data, exp_w[w]);
        end else check({nm, "_extra_write"}, 64'(w), 64'(NWIN - 1));
        w++;
      end
      if (n_done > 0 && cyc >= done_cyc + 4) break;
      @(posedge clk);
    end
    start = 1'b0;
    wr_ready = 1'b1;
    check({nm, "_writes"}, 64'(w), 64'(NWIN));
    check({nm, "_done_pulses"}, 64'(n_done), 64'd1);
    check({nm, "_done_cycle"}, 64'(done_cyc), 64'(217 + stalls));
    check({nm, "_busy"}, 64'(busy_err), 64'd0);
    check({nm, "_after_done"}, 64'(post_err), 64'd0);
    check({nm, "_rd_wr_overlap"}, 64'(proto_err), 64'd0);
    if (mode == 1) check({nm, "_done_222"}, 64'(done_cyc), 64'd222);
  endtask

  task automatic abort_test();
    int w, n_done;
    bit hit;
    w = 0; n_done = 0; hit = 1'b0;
    fill_random();
    start = 1'b1;
    wr_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      #1;
      start = 1'b0;
      if (wr_valid) w++;
      if (w == 20 && rd_en) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check("abort_reached_win20", 64'(hit), 64'd1);
    soft_rst = 1'b1;
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_wr_valid", 64'(wr_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (done || busy) n_done++;
      @(posedge clk);
      #1;
    end
    check("abort_quiet", 64'(n_done), 64'd0);
  endtask

  task automatic async_reset_test();
    bit hit;
    int idle_err;
    hit = 1'b0; idle_err = 0;
    fill_random();
    start = 1'b1;
    wr_ready = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      #1;
      start = 1'b0;
      if (wr_valid) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check("arst_in_write", 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_rd_en", 64'(rd_en), 64'd0);
    check("arst_rd_addr", 64'(rd_addr), 64'd0);
    check("arst_wr_valid", 64'(wr_valid), 64'd0);
    check("arst_wr_addr", 64'(wr_addr), 64'd0);
    check("arst_wr_data", wr_data, 64'd0);
    #2 rst_n = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (busy || rd_en || wr_valid || done) idle_err++;
    end
    check("arst_stays_idle", 64'(idle_err), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    soft_rst = 1'b0;
    start = 1'b0;
    wr_ready = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill_ramp();
    run_frame(0, 1'b0, "ramp");
    check("ramp_w0_ch0", 64'(got_w[0][7:0]), 64'd13);
    check("ramp_w35_ch0", 64'(got_w[35][7:0]), 64'd143);
    check("ramp_w35_ch7", 64'(got_w[35][63:56]), 64'd150);

    fill_position();
    run_frame(0, 1'b0, "winmax");
    check("winmax_w1", got_w[1], {8{8'd200}});
    check("winmax_w0_equal", got_w[0], {8{8'd7}});

    fill_random();
    run_frame(1, 1'b0, "stall");

    fill_random();
    run_frame(2, 1'b0, "randbp");

    abort_test();
    fill_random();
    run_frame(0, 1'b0, "after_abort");

    fill_random();
    run_frame(0, 1'b1, "startbusy");

    async_reset_test();
    fill_random();
    run_frame(2, 1'b0, "after_arst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
